mem_port_arbiter: RTL

//  Shares the single main-memory word port (4 x 8-bit lanes, write enable, fixed latency)

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory word port (4 x 8-bit lanes, fixed latency)
//   between the instruction cache (port 0) and the data cache (port 1).
//   Serialises accesses, sequences memory timing and returns a one-cycle
//   done pulse with read data. Callers keep no latency counters.
//
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   req0/1, we0/1            request (held until done) and write flag
//   addr0/1, wdata0/1        word address and write lanes [0:3]
//   gnt0/1                   port owns memory (ACCESS or RESP)
//   done0/1                  one-cycle completion pulse
//   rdata0/1                 read lanes, held until that port's next read
//   busy                     arbiter not idle
//   mem_addr, mem_data_in    address / write lanes to memory
//   mem_write_en             write strobe (first access cycle only)
//   mem_data_out             read lanes from memory
module mem_port_arbiter #(
  parameter int READ_LAT  = 5,
  parameter int WRITE_LAT = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [31:0]     addr0,
  input  logic [31:0]     addr1,
  input  logic [0:3][7:0] wdata0,
  input  logic [0:3][7:0] wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [0:3][7:0] rdata0,
  output logic [0:3][7:0] rdata1,
  output logic            busy,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  output logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_out
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] RD_END = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_END = CW'(WRITE_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last;   // port granted most recently; loser of the next tie
  logic          owner;  // port owning the current access
  logic          we_q;
  logic          sel;    // port to grant when leaving IDLE
  logic          acc_end;

  // Lone requester wins; on a tie the port that did not go last wins.
  always_comb begin
    sel = req1 & (~req0 | ~last);
  end

  always_comb begin
    acc_end = we_q ? (cnt == WR_END) : (cnt == RD_END);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last         <= 1'b1;
      owner        <= 1'b0;
      we_q         <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_write_en <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            owner        <= sel;
            last         <= sel;
            we_q         <= sel ? we1 : we0;
            mem_addr     <= sel ? addr1 : addr0;
            mem_data_in  <= sel ? wdata1 : wdata0;
            mem_write_en <= sel ? we1 : we0;
            gnt0         <= ~sel;
            gnt1         <= sel;
            cnt          <= '0;
            state        <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt          <= cnt + 1'b1;
          mem_write_en <= 1'b0;
          if (acc_end) begin
            // mem_data_out is valid in the last latency cycle only.
            if (!we_q) begin
              if (owner) rdata1 <= mem_data_out;
              else       rdata0 <= mem_data_out;
            end
            state <= S_RESP;
          end
        end
        S_RESP: begin
          // Two edges in RESP: the first raises done, the second retires the
          // access. The requester drops req at the edge where it sees done,
          // so IDLE must not sample reqs before that edge has passed.
          if (!(done0 | done1)) begin
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            done0       <= 1'b0;
            done1       <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
